// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit, bundled for port connection.
// Handshake: a request transfers on the rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse, no back-pressure.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned accesses to a memory without byte enables,
// sub-word stores done as read-modify-write, misaligned/illegal requests answered with an error.
module load_store_unit #(
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_legal;
  logic        req_aligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_word;

  // Stores only have byte/half/word codes; loads add the unsigned byte/half codes.
  always_comb begin
    req_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !bus.req_write;
      default:                req_legal = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b01:   req_aligned = !bus.req_addr[0];
      2'b10:   req_aligned = (bus.req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // Merge the store data into the word fetched during the read phase.
  always_comb begin
    st_word = word_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    st_word[7:0]   = wdata_q[7:0];
          2'd1:    st_word[15:8]  = wdata_q[7:0];
          2'd2:    st_word[23:16] = wdata_q[7:0];
          default: st_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
        else           st_word[15:0]  = wdata_q[15:0];
      end
      default: st_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (!(req_legal && req_aligned)) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (bus.req_write && (bus.req_funct3[1:0] == 2'b10)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        word_d = bus.mem_rdata;
        if (write_q) begin
          state_d = S_WR;
        end else begin
          state_d      = S_RESP;
          resp_rdata_d = ld_ext;
          resp_err_d   = 1'b0;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      word_q       <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory strobes come from state alone so a reset drops them immediately.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_read   = (state_q == S_RD);
  assign bus.mem_write  = (state_q == S_WR);
  assign bus.mem_wdata  = (state_q == S_WR) ? st_word : 32'h0;
  // Bits above the decoded range are forwarded untouched; data_mem aliases them.
  assign bus.mem_addr   = {addr_q[31:MEM_ADDR_BITS], addr_q[MEM_ADDR_BITS-1:2], 2'b00};
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory behind the unit, byte-level reference model with a
// transaction queue, per-cycle compare process, directed literal cases and random traffic.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  logic [1:0] dbg_state;

  load_store_unit #(.MEM_ADDR_BITS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int last_lat = 0;
  logic [31:0] last_wdata = 32'h0;

  logic [31:0] envm [256];
  logic [7:0]  refm [1024];
  logic        mem_init_done = 1'b0;

  typedef struct {
    logic        w;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wword;
    logic [31:0] maddr;
    logic [31:0] d;
    int          idx;
    int          size;
    int          nreads;
    int          nwrites;
    int          lat;
    int          acc;
  } txn_t;

  txn_t txn_q[$];
  txn_t cur;
  int   seen_reads = 0;
  int   seen_writes = 0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // Data memory: combinational read, write at the rising edge, low 10 address bits decoded.
  assign bus.mem_rdata = envm[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) envm[i] <= init_word(i);
    end else if (bus.mem_write) begin
      envm[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] ref_word(int base);
    return {refm[base+3], refm[base+2], refm[base+1], refm[base]};
  endfunction

  // Expected outcome of one request, from the byte-array view of memory.
  function automatic txn_t build(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    txn_t t;
    logic legal;
    logic [7:0] wb [4];
    int base;
    logic [31:0] v;
    t.w     = w;
    t.d     = d;
    t.size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal   = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    t.err   = !legal || ((int'(a[1:0]) % t.size) != 0);
    t.idx   = int'(a[9:0]);
    base    = t.idx - int'(a[1:0]);
    t.maddr = {a[31:2], 2'b00};
    t.rdata = 32'h0;
    t.wword = 32'h0;
    if (!t.err && !w) begin
      v = 32'h0;
      for (int k = 0; k < t.size; k++) v |= 32'(refm[t.idx+k]) << (8*k);
      if (!f3[2] && t.size < 4 && v[8*t.size-1]) v |= 32'hFFFFFFFF << (8*t.size);
      t.rdata = v;
    end
    if (!t.err && w) begin
      for (int k = 0; k < 4; k++) wb[k] = refm[base+k];
      for (int k = 0; k < t.size; k++) wb[int'(a[1:0])+k] = d[8*k +: 8];
      t.wword = {wb[3], wb[2], wb[1], wb[0]};
    end
    t.nreads  = (!t.err && (!w || t.size < 4)) ? 1 : 0;
    t.nwrites = (!t.err && w) ? 1 : 0;
    t.lat     = t.err ? 1 : (w && t.size < 4) ? 3 : 2;
    t.acc     = 0;
    return t;
  endfunction

  // Compare process: checks every cycle against the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst_n) begin
      txn_q.delete();
      seen_reads  = 0;
      seen_writes = 0;
      chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
    end else begin
      chk("req_ready", 32'(bus.req_ready), 32'(txn_q.size() == 0));
      if (bus.mem_read && bus.mem_write) chk("rd_wr_exclusive", 32'(bus.mem_write), 32'h0);
      if (bus.mem_read) begin
        seen_reads++;
        if (txn_q.size() == 0) chk("stray_mem_read", 32'(bus.mem_read), 32'h0);
        else chk("mem_addr_rd", bus.mem_addr, txn_q[0].maddr);
      end
      if (bus.mem_write) begin
        seen_writes++;
        last_wdata = bus.mem_wdata;
        if (txn_q.size() == 0) chk("stray_mem_write", 32'(bus.mem_write), 32'h0);
        else begin
          chk("mem_addr_wr", bus.mem_addr, txn_q[0].maddr);
          chk("mem_wdata", bus.mem_wdata, txn_q[0].wword);
        end
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        if (txn_q.size() == 0) chk("stray_resp", 32'(bus.resp_valid), 32'h0);
        else begin
          cur = txn_q.pop_front();
          last_lat = cyc - cur.acc + 1;
          chk("resp_rdata", bus.resp_rdata, cur.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(cur.err));
          chk("latency", 32'(last_lat), 32'(cur.lat));
          chk("read_count", 32'(seen_reads), 32'(cur.nreads));
          chk("write_count", 32'(seen_writes), 32'(cur.nwrites));
          if (cur.w && !cur.err)
            for (int k = 0; k < cur.size; k++) refm[cur.idx+k] = cur.d[8*k +: 8];
        end
        seen_reads  = 0;
        seen_writes = 0;
      end
      if (bus.req_valid && bus.req_ready) begin
        cur = build(bus.req_write, bus.req_funct3, bus.req_addr, bus.req_wdata);
        cur.acc = cyc + 1;
        txn_q.push_back(cur);
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er);
    bit ok;
    rd = 32'h0;
    er = 1'b0;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ok = 1'b1;
        rd = bus.resp_rdata;
        er = bus.resp_err;
        break;
      end
    end
    if (!ok) fail_now("resp_timeout");
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc_cyc [3];
  int          start_cnt;
  bit          ok;
  logic [31:0] ra;

  initial begin
    rst_n          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) refm[4*i+k] = init_word(i)[8*k +: 8];
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_init_done = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    chk("sw_lat", 32'(last_lat), 32'd2);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(last_lat), 32'd2);

    do_req(1'b1, 3'b010, 32'h10, 32'h11223344, rd, er);
    do_req(1'b1, 3'b000, 32'h12, 32'h000000AA, rd, er);
    chk("sb_wdata", last_wdata, 32'h11AA3344);
    chk("sb_lat", 32'(last_lat), 32'd3);
    chk("sb_rdata", rd, 32'h0);

    do_req(1'b1, 3'b010, 32'h20, 32'h8000F0FF, rd, er);
    do_req(1'b0, 3'b000, 32'h20, 32'h0, rd, er);
    chk("lb_20", rd, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 32'h21, 32'h0, rd, er);
    chk("lbu_21", rd, 32'h000000F0);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, er);
    chk("lh_22", rd, 32'hFFFF8000);
    do_req(1'b0, 3'b101, 32'h22, 32'h0, rd, er);
    chk("lhu_22", rd, 32'h00008000);

    do_req(1'b0, 3'b001, 32'h21, 32'h0, rd, er);
    chk("lh_mis_err", 32'(er), 32'h1);
    chk("lh_mis_lat", 32'(last_lat), 32'd1);
    do_req(1'b1, 3'b010, 32'h22, 32'h12345678, rd, er);
    chk("sw_mis_err", 32'(er), 32'h1);
    chk("sw_mis_rdata", rd, 32'h0);
    do_req(1'b0, 3'b011, 32'h20, 32'h0, rd, er);
    chk("f3_011_err", 32'(er), 32'h1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
    chk("lw_after_err", rd, 32'h8000F0FF);
    chk("err_cleared", 32'(er), 32'h0);

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[31:10] = 22'h0;
      ra[9:0] = 10'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, rd, er);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Three SW with req_valid held high throughout.
    start_cnt = resp_cnt;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = $urandom;
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("b2b_accept_timeout");
      @(posedge clk); #1;
      acc_cyc[k] = cyc;
      if (k < 2) begin
        bus.req_addr  = bus.req_addr + 32'h4;
        bus.req_wdata = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    chk("b2b_resp_count", 32'(resp_cnt - start_cnt), 32'd3);
    chk("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

    // SH interrupted by reset during its read phase.
    do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, rd, er);
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'h00001234;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("sh_accept_timeout");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("sh_in_rd", 32'(bus.mem_read), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_write", 32'(bus.mem_write), 32'h0);
    chk("rst_async_read", 32'(bus.mem_read), 32'h0);
    chk("rst_async_ready", 32'(bus.req_ready), 32'h1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'h1);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er);
    chk("word30_unchanged", rd, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 256; i++) chk("mem_final", envm[i], ref_word(4*i));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
